mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arm_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/wait_timer.sv | 45 ++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the memory arbiter between the pipeline and the
// unified instruction/data memory.
package arm_pkg;

  // Arbiter sequencing: an optional data access always precedes the fetch.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Cycles without MemAck before an access is abandoned.
  localparam int WAIT_LIMIT_DEF = 15;

  // Word returned to the pipeline in place of an access that timed out.
  localparam logic [31:0] ABORT_WORD = 32'h0000_0000;

endpackage : arm_pkg

// File: rtl/mem_arbiter_if.sv
// Unified memory request/response bus. The arbiter drives the request side;
// the memory answers with read data and a single-cycle acknowledge.
interface mem_arbiter_if;

  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;

  modport master (
    output MemReq, MemWE, MemAddr, MemWData,
    input  MemRData, MemAck
  );

  modport slave (
    input  MemReq, MemWE, MemAddr, MemWData,
    output MemRData, MemAck
  );

endinterface : mem_arbiter_if

// File: rtl/wait_timer.sv
// Access timeout counter: cleared while no access is waiting, counts cycles
// spent waiting for MemAck, and flags the cycle in which the wait budget
// runs out so the arbiter can abort in that same cycle.
module wait_timer
  import arm_pkg::*;
#(
  parameter int LIMIT = WAIT_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CntW = (LIMIT < 16) ? 4 : $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Next count: clear wins over counting.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The LIMIT-th consecutive cycle without an acknowledge is the last one.
  assign expired_o = enable_i && !clear_i && (cnt_q == CntW'(LIMIT - 1));

endmodule : wait_timer

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the
// Memory-stage load/store. Each pipeline step performs the data access first,
// then the fetch, freezing the whole pipeline until the DONE cycle presents
// the results. Pipeline inputs are used live because StallMem holds them.
module mem_arbiter
  import arm_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PCF,
  input  logic                 FetchReq,
  input  logic [31:0]          ALUOutM,
  input  logic [31:0]          WriteDataM,
  input  logic                 MemWriteM,
  input  logic                 MemReadM,
  output logic [31:0]          InstrF,
  output logic [31:0]          ReadDataM,
  output logic                 FetchValid,
  output logic                 DataValid,
  output logic                 StallMem,
  output logic                 BusError,
  mem_arbiter_if.master        mem
);

  arb_state_e  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fetch_done_q, fetch_done_d;
  logic        load_done_q, load_done_d;
  logic        buserr_q, buserr_d;

  logic data_req;
  logic is_load;
  logic in_access;
  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;

  assign data_req  = MemWriteM | MemReadM;
  // A simultaneous read and write is treated as a store.
  assign is_load   = MemReadM & ~MemWriteM;
  assign in_access = (state_q == DATA) || (state_q == FETCH);

  // Counting only while an access waits; an acknowledge restarts the budget
  // for the following access.
  assign tmr_clear  = !in_access || mem.MemAck;
  assign tmr_enable = in_access && !mem.MemAck;

  wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .expired_o (tmr_expired)
  );

  // Next-state and holding-register updates for one pipeline step.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    rdata_d      = rdata_q;
    fetch_done_d = fetch_done_q;
    load_done_d  = load_done_q;
    buserr_d     = buserr_q;
    unique case (state_q)
      IDLE: begin
        if (data_req || FetchReq) begin
          state_d      = data_req ? DATA : FETCH;
          fetch_done_d = 1'b0;
          load_done_d  = 1'b0;
        end
      end
      DATA: begin
        if (mem.MemAck) begin
          if (is_load) begin
            rdata_d     = mem.MemRData;
            load_done_d = 1'b1;
          end
          state_d = FetchReq ? FETCH : DONE;
        end else if (tmr_expired) begin
          if (is_load) rdata_d = ABORT_WORD;
          buserr_d = 1'b1;
          state_d  = DONE;
        end
      end
      FETCH: begin
        if (mem.MemAck) begin
          instr_d      = mem.MemRData;
          fetch_done_d = 1'b1;
          state_d      = DONE;
        end else if (tmr_expired) begin
          instr_d  = ABORT_WORD;
          buserr_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the holding registers are reset so InstrF/ReadDataM read 0 afterwards.
      state_q      <= IDLE;
      instr_q      <= '0;
      rdata_q      <= '0;
      fetch_done_q <= 1'b0;
      load_done_q  <= 1'b0;
      buserr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      rdata_q      <= rdata_d;
      fetch_done_q <= fetch_done_d;
      load_done_q  <= load_done_d;
      buserr_q     <= buserr_d;
    end
  end

  // Memory request; reset kills it immediately, even mid-access.
  assign mem.MemReq   = in_access && !reset;
  assign mem.MemWE    = (state_q == DATA) && MemWriteM && !reset;
  assign mem.MemAddr  = (state_q == FETCH) ? PCF :
                        (state_q == DATA)  ? ALUOutM : '0;
  assign mem.MemWData = (state_q == DATA) ? WriteDataM : '0;

  // Pipeline side.
  assign StallMem   = in_access || ((state_q == IDLE) && (data_req || FetchReq));
  assign FetchValid = (state_q == DONE) && fetch_done_q;
  assign DataValid  = (state_q == DONE) && load_done_q;
  assign InstrF     = instr_q;
  assign ReadDataM  = rdata_q;
  assign BusError   = buserr_q;

endmodule : mem_arbiter
